// File: rtl/key_dec_pkg.sv
// Shared state encoding and width helpers for the serial key/mode decoder.
package key_dec_pkg;

   typedef enum logic [3:0] {
      ST_HUNT   = 4'b0001,
      ST_ARM    = 4'b0010,
      ST_ACTIVE = 4'b0100,
      ST_LOCKED = 4'b1000
   } state_t;

   // Keeps degenerate counters at least one bit wide.
   function automatic int unsigned at_least_one(input int unsigned w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/key_mode_shifter.sv
// Serial-to-parallel mode word assembler: MSB-first shift history plus a bit
// counter that strobes done_c on the bit completing a word.
module key_mode_shifter
   import key_dec_pkg::*;
#(
   parameter int unsigned MODE_W = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              shift_en,
   input  logic              bit_in,
   output logic [MODE_W-1:0] word_c,
   output logic              done_c
);

   localparam int unsigned MC_W = at_least_one($clog2(MODE_W));

   logic [MC_W-1:0] mcnt;

   assign done_c = shift_en && (mcnt == MC_W'(MODE_W - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcnt <= '0;
      end else if (clr) begin
         mcnt <= '0;
      end else if (shift_en) begin
         mcnt <= done_c ? '0 : mcnt + MC_W'(1);
      end
   end

   // Only MODE_W-1 bits of history are stored; the newest bit completes the word.
   generate
      if (MODE_W > 1) begin : g_hist
         logic [MODE_W-2:0] mshift;

         assign word_c = {mshift, bit_in};

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               mshift <= '0;
            end else if (clr) begin
               mshift <= '0;
            end else if (shift_en) begin
               mshift <= word_c[MODE_W-2:0];
            end
         end
      end else begin : g_single
         assign word_c = bit_in;
      end
   endgenerate

endmodule

// File: rtl/key_seq_decoder.sv
// Serial key decoder and mode selector: matches a programmable unlock pattern,
// then assembles mode words, with failed-attempt lockout and timed recovery.
module key_seq_decoder
   import key_dec_pkg::*;
#(
   parameter int unsigned        KEY_LEN  = 4,
   parameter logic [KEY_LEN-1:0] KEY      = KEY_LEN'(4'b1010),
   parameter int unsigned        MODE_W   = 1,
   parameter int unsigned        MAX_FAIL = 3,
   parameter int unsigned        LOCK_CYC = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              input_key,
   input  logic              valid_cmd,
   input  logic              deact,
   output logic              active,
   output logic [MODE_W-1:0] mode,
   output logic              mode_vld,
   output logic              locked,
   output logic              key_ok
);

   localparam int unsigned IDX_W = $clog2(KEY_LEN + 1);
   localparam int unsigned FC_W  = at_least_one($clog2(MAX_FAIL + 1));
   localparam int unsigned TM_W  = $clog2(LOCK_CYC + 1);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [FC_W-1:0]   fail_cnt, fail_nxt, fail_inc;
   logic [TM_W-1:0]   timer, timer_nxt;
   logic              active_nxt, mode_vld_nxt, locked_nxt, key_ok_nxt;
   logic [MODE_W-1:0] mode_nxt;

   logic [KEY_LEN-1:0] key_sel;
   logic               key_bit_c;
   logic               shift_en, clr;
   logic [MODE_W-1:0]  word_c;
   logic               done_c;

   // Expected key bit, MSB first, selected by the match index.
   assign key_sel   = KEY_LEN'(1) << (IDX_W'(KEY_LEN - 1) - idx);
   assign key_bit_c = |(KEY & key_sel);
   assign fail_inc  = fail_cnt + FC_W'(1);

   assign shift_en = valid_cmd && !deact && ((state == ST_ARM) || (state == ST_ACTIVE));
   assign clr      = deact && (state != ST_LOCKED);

   key_mode_shifter #(
      .MODE_W (MODE_W)
   ) u_shifter (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .shift_en (shift_en),
      .bit_in   (input_key),
      .word_c   (word_c),
      .done_c   (done_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_HUNT;
         idx      <= '0;
         fail_cnt <= '0;
         timer    <= '0;
         active   <= 1'b0;
         mode     <= '0;
         mode_vld <= 1'b0;
         locked   <= 1'b0;
         key_ok   <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         fail_cnt <= fail_nxt;
         timer    <= timer_nxt;
         active   <= active_nxt;
         mode     <= mode_nxt;
         mode_vld <= mode_vld_nxt;
         locked   <= locked_nxt;
         key_ok   <= key_ok_nxt;
      end
   end

   // Lockout outranks deact, which outranks an accepted bit.
   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      fail_nxt     = fail_cnt;
      timer_nxt    = timer;
      active_nxt   = active;
      mode_nxt     = mode;
      locked_nxt   = locked;
      mode_vld_nxt = 1'b0;
      key_ok_nxt   = 1'b0;

      if (state == ST_LOCKED) begin
         if (timer == '0) begin
            state_nxt  = ST_HUNT;
            locked_nxt = 1'b0;
            fail_nxt   = '0;
         end else begin
            timer_nxt = timer - TM_W'(1);
         end
      end else if (deact) begin
         state_nxt  = ST_HUNT;
         active_nxt = 1'b0;
         mode_nxt   = '0;
         idx_nxt    = '0;
      end else if (valid_cmd) begin
         case (state)
            ST_HUNT: begin
               if (input_key == key_bit_c) begin
                  if (idx == IDX_W'(KEY_LEN - 1)) begin
                     idx_nxt    = '0;
                     key_ok_nxt = 1'b1;
                     fail_nxt   = '0;
                     state_nxt  = ST_ARM;
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end else begin
                  // No overlap re-check; a miss at idx 0 is treated as noise.
                  idx_nxt = '0;
                  if (idx != '0) begin
                     if (fail_cnt != '1) begin
                        fail_nxt = fail_inc;
                     end
                     if ((MAX_FAIL != 0) && (fail_inc == FC_W'(MAX_FAIL))) begin
                        state_nxt  = ST_LOCKED;
                        locked_nxt = 1'b1;
                        timer_nxt  = TM_W'(LOCK_CYC - 1);
                     end
                  end
               end
            end
            ST_ARM, ST_ACTIVE: begin
               if (done_c) begin
                  mode_nxt     = word_c;
                  mode_vld_nxt = 1'b1;
                  active_nxt   = 1'b1;
                  state_nxt    = ST_ACTIVE;
               end
            end
            default: begin
               state_nxt = ST_HUNT;
               idx_nxt   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_seq_decoder.sv
// Bench for key_seq_decoder: a default instance and a MODE_W=3 instance share
// stimulus and are compared each cycle against a behavioural model.
module tb_key_seq_decoder;

   localparam int KEY_LEN  = 4;
   localparam int KEY_VAL  = 10;
   localparam int MAX_FAIL = 3;
   localparam int LOCK_CYC = 16;
   localparam int MW0      = 1;
   localparam int MW1      = 3;

   localparam int PH_HUNT   = 0;
   localparam int PH_ARM    = 1;
   localparam int PH_ACTIVE = 2;
   localparam int PH_LOCKED = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic input_key = 1'b0;
   logic valid_cmd = 1'b0;
   logic deact = 1'b0;

   logic           active0, mode_vld0, locked0, key_ok0;
   logic [MW0-1:0] mode0;
   logic           active1, mode_vld1, locked1, key_ok1;
   logic [MW1-1:0] mode1;

   int checks = 0;
   int errors = 0;

   int m_phase[2], m_matched[2], m_fails[2], m_lock_left[2], m_nbits[2], m_acc[2];
   int e_active[2], e_mode[2], e_mvld[2], e_locked[2], e_keyok[2];

   key_seq_decoder u_dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .input_key (input_key),
      .valid_cmd (valid_cmd),
      .deact     (deact),
      .active    (active0),
      .mode      (mode0),
      .mode_vld  (mode_vld0),
      .locked    (locked0),
      .key_ok    (key_ok0)
   );

   key_seq_decoder #(.MODE_W(MW1)) u_dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .input_key (input_key),
      .valid_cmd (valid_cmd),
      .deact     (deact),
      .active    (active1),
      .mode      (mode1),
      .mode_vld  (mode_vld1),
      .locked    (locked1),
      .key_ok    (key_ok1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int mw(input int k);
      return (k == 0) ? MW0 : MW1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = PH_HUNT; m_matched[k] = 0; m_fails[k] = 0;
         m_lock_left[k] = 0; m_nbits[k] = 0; m_acc[k] = 0;
         e_active[k] = 0; e_mode[k] = 0; e_mvld[k] = 0;
         e_locked[k] = 0; e_keyok[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input logic v, input logic b, input logic d);
      int kb;
      e_mvld[k]  = 0;
      e_keyok[k] = 0;
      if (m_phase[k] == PH_LOCKED) begin
         m_lock_left[k]--;
         if (m_lock_left[k] == 0) begin
            m_phase[k] = PH_HUNT; e_locked[k] = 0; m_fails[k] = 0;
         end
      end else if (d) begin
         m_phase[k] = PH_HUNT; e_active[k] = 0; e_mode[k] = 0;
         m_matched[k] = 0; m_nbits[k] = 0; m_acc[k] = 0;
      end else if (v) begin
         if (m_phase[k] == PH_HUNT) begin
            kb = (KEY_VAL >> (KEY_LEN - 1 - m_matched[k])) & 1;
            if (int'(b) == kb) begin
               m_matched[k]++;
               if (m_matched[k] == KEY_LEN) begin
                  m_matched[k] = 0; e_keyok[k] = 1; m_fails[k] = 0; m_phase[k] = PH_ARM;
               end
            end else begin
               if (m_matched[k] > 0) begin
                  m_fails[k]++;
                  if (m_fails[k] == MAX_FAIL) begin
                     m_phase[k] = PH_LOCKED; e_locked[k] = 1; m_lock_left[k] = LOCK_CYC;
                  end
               end
               m_matched[k] = 0;
            end
         end else begin
            m_acc[k] = m_acc[k] * 2 + int'(b);
            m_nbits[k]++;
            if (m_nbits[k] == mw(k)) begin
               e_mode[k] = m_acc[k]; e_mvld[k] = 1; e_active[k] = 1;
               m_phase[k] = PH_ACTIVE; m_nbits[k] = 0; m_acc[k] = 0;
            end
         end
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k, valid_cmd, input_key, deact);
   end

   always @(negedge clk) begin
      check("active0",   int'(active0),   e_active[0]);
      check("mode0",     int'(mode0),     e_mode[0]);
      check("mode_vld0", int'(mode_vld0), e_mvld[0]);
      check("locked0",   int'(locked0),   e_locked[0]);
      check("key_ok0",   int'(key_ok0),   e_keyok[0]);
      check("active1",   int'(active1),   e_active[1]);
      check("mode1",     int'(mode1),     e_mode[1]);
      check("mode_vld1", int'(mode_vld1), e_mvld[1]);
      check("locked1",   int'(locked1),   e_locked[1]);
      check("key_ok1",   int'(key_ok1),   e_keyok[1]);
   end

   task automatic tick(input logic v, input logic b, input logic d);
      valid_cmd = v; input_key = b; deact = d;
      @(negedge clk);
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) tick(1'b1, s[i] == 8'h31, 1'b0);
   endtask

   task automatic async_reset();
      valid_cmd = 1'b0; deact = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_active", int'(active0), 0);
      check("rst_mode", int'(mode0), 0);
      check("rst_locked", int'(locked0), 0);
      check("rst_key_ok", int'(key_ok0), 0);
      check("rst_mode_vld", int'(mode_vld0), 0);
      reset_n = 1'b1;

      // Default key then single-bit modes
      send("1010");
      check("a_key_ok0", int'(key_ok0), 1);
      check("a_key_ok1", int'(key_ok1), 1);
      check("a_active_pre", int'(active0), 0);
      send("1");
      check("a_active", int'(active0), 1);
      check("a_mode1", int'(mode0), 1);
      check("a_mvld", int'(mode_vld0), 1);
      check("a_key_ok_pulse", int'(key_ok0), 0);
      send("0");
      check("a_mode0", int'(mode0), 0);
      check("a_mvld2", int'(mode_vld0), 1);
      tick(1'b0, 1'b0, 1'b0);
      check("a_mvld_drop", int'(mode_vld0), 0);
      tick(1'b0, 1'b0, 1'b1);
      check("a_deact", int'(active0), 0);

      // Three-bit modes with a gap
      send("1010");
      send("1");
      tick(1'b0, 1'b0, 1'b0);
      send("1");
      check("b_active_wait", int'(active1), 0);
      send("0");
      check("b_active", int'(active1), 1);
      check("b_mode110", int'(mode1), 6);
      check("b_dut0_mode", int'(mode0), 0);
      send("0");
      tick(1'b0, 1'b0, 1'b0);
      send("0");
      check("b_active_hold", int'(active1), 1);
      check("b_mode_hold", int'(mode1), 6);
      send("1");
      check("b_mode001", int'(mode1), 1);
      check("b_mvld1", int'(mode_vld1), 1);

      // deact with a bit while active
      tick(1'b1, 1'b1, 1'b1);
      check("e_active0", int'(active0), 0);
      check("e_mode0", int'(mode0), 0);
      check("e_active1", int'(active1), 0);
      check("e_mode1", int'(mode1), 0);
      check("e_mvld0", int'(mode_vld0), 0);

      // Lockout after three counted failures
      send("11111");
      check("c_locked_pre", int'(locked0), 0);
      send("1");
      check("c_locked0", int'(locked0), 1);
      check("c_locked1", int'(locked1), 1);
      for (int i = 1; i < LOCK_CYC; i++) begin
         tick(1'b1, (i % 2) == 1, (i == 3) || (i == 9));
         check("c_locked_hold", int'(locked0), 1);
      end
      tick(1'b1, 1'b0, 1'b0);
      check("c_release", int'(locked0), 0);
      send("1010");
      check("c_key_ok", int'(key_ok0), 1);
      send("0");
      check("c_active", int'(active0), 1);
      check("c_mode", int'(mode0), 0);
      tick(1'b0, 1'b0, 1'b1);

      // Zeros are noise
      for (int i = 0; i < 10; i++) begin
         send("0");
         check("d_locked", int'(locked0), 0);
         check("d_key_ok", int'(key_ok0), 0);
      end
      send("1010");
      check("d_key_ok_after", int'(key_ok0), 1);
      send("1");
      check("d_active", int'(active0), 1);

      // Asynchronous reset while active
      async_reset();
      check("f_rst_active", int'(active0), 0);
      check("f_rst_mode", int'(mode0), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset mid-key
      send("10");
      async_reset();
      check("f_rst_midkey", int'(key_ok0), 0);
      @(negedge clk);
      reset_n = 1'b1;
      send("10");
      check("f_no_partial", int'(key_ok0), 0);
      send("10");
      check("f_key_ok", int'(key_ok0), 1);
      send("1");
      check("f_active", int'(active0), 1);
      tick(1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-lockout
      send("111111");
      check("f_locked", int'(locked0), 1);
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      async_reset();
      check("f_rst_locked0", int'(locked0), 0);
      check("f_rst_locked1", int'(locked1), 0);
      @(negedge clk);
      reset_n = 1'b1;
      send("1010");
      check("f_key_ok2", int'(key_ok0), 1);
      send("1");
      check("f_active2", int'(active0), 1);
      check("f_mode2", int'(mode0), 1);

      repeat (3) tick(1'b0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_seq_decoder.md
# key_seq_decoder

Parametrised serial key decoder and mode selector for the command front-end. It consumes one key bit per qualified cycle and matches a programmable unlock pattern. Once unlocked, it assembles multi-bit mode words and holds `active`/`mode` for the downstream datapath. Added over the single-pattern decoder: configurable key and mode widths, explicit deactivation, failed-attempt lockout with timed recovery, and status outputs. With default parameters the block is behaviourally compatible with the existing 1010-then-mode-bit decoder.

## Interface
- `KEY_LEN`, default 4: unlock pattern length in bits, ≥1.
- `KEY`, default 4'b1010: unlock pattern, compared MSB first.
- `MODE_W`, default 1: mode word width, ≥1.
- `MAX_FAIL`, default 3: consecutive failed attempts before lockout; 0 disables lockout.
- `LOCK_CYC`, default 16: lockout duration in clock cycles, ≥1.
- `clk` in, 1: single clock; all logic on the rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `input_key` in, 1: serial key/mode bit.
- `valid_cmd` in, 1: qualifies `input_key` for this cycle.
- `deact` in, 1: synchronous request to drop back to HUNT.
- `active` out, 1: unlocked and mode valid.
- `mode` out, MODE_W: current mode word.
- `mode_vld` out, 1: one-cycle pulse when `mode` is updated.
- `locked` out, 1: lockout in progress.
- `key_ok` out, 1: one-cycle pulse on full key match.

## Operation
- States: HUNT, ARM, ACTIVE, LOCKED. A bit is *accepted* when `valid_cmd`=1, `deact`=0 and the state is not LOCKED.
- **HUNT**: `idx` counts matched bits, starting at 0.
  - Accepted bit == `KEY[KEY_LEN-1-idx]`: `idx`++. On the last bit: `idx`←0, pulse `key_ok`, clear `fail_cnt`, go to ARM.
  - Mismatch: `idx`←0 and the bit is discarded (no overlap re-evaluation).
  - Mismatch with `idx`>0 is a failure: `fail_cnt`++. If `MAX_FAIL`≠0 and `fail_cnt` reaches `MAX_FAIL`, go to LOCKED. Mismatch at `idx`=0 is noise and is not counted.
- **ARM**: shift accepted bits into `mshift`, MSB first; `mcnt` counts them. On the MODE_W-th bit: `mode`←assembled word, pulse `mode_vld`, `active`←1, `mcnt`←0, go to ACTIVE.
- **ACTIVE**: same assembly as ARM. Every MODE_W accepted bits: update `mode` and pulse `mode_vld`. `active` stays 1 and `mode` holds between updates.
- **LOCKED**: `locked`=1 and the timer loads `LOCK_CYC-1`. All `valid_cmd` input is ignored. When the timer reaches 0, the next edge goes to HUNT with `fail_cnt`←0 and `locked`←0.
- **`deact`** in HUNT, ARM or ACTIVE:
  - next state HUNT; `active`←0, `mode`←0;
  - `idx`, `mcnt`, `mshift` cleared;
  - `fail_cnt` kept.
  - In LOCKED, `deact` is ignored.
- **Priority**: reset > LOCKED > `deact` > accepted bit. A bit presented together with `deact` is dropped.
- **Reset values**: state HUNT; `active`=0, `mode`=0, `mode_vld`=0, `locked`=0, `key_ok`=0; all counters 0.

## Timing
- All outputs are registered and change on the edge that accepts the triggering bit. Latency from bit to output is one edge.
- Key completion to `active`: exactly MODE_W further accepted bits.
- `valid_cmd` may be held high continuously (one bit per cycle), or gapped arbitrarily; gaps do not time out.
- Lockout: `locked` is high for exactly `LOCK_CYC` cycles, starting the edge after the failing bit is accepted.
- `mode_vld` and `key_ok` are single-cycle pulses and never stretch.
- Counter widths: `idx` is clog2(KEY_LEN+1), `mcnt` is max(1, clog2(MODE_W)), `fail_cnt` is clog2(MAX_FAIL+1), timer is clog2(LOCK_CYC+1).

## Structure
- The state enum (one-hot, 4 bits) and its encodings go in the shared package `key_dec_pkg`.
- One sub-module, `key_mode_shifter`: a MODE_W-bit shift register plus `mcnt`, producing the word and a done strobe. It is used in ARM and ACTIVE.
- Matcher, fail/lock logic and the FSM stay in the top level.

## Test plan
- Default parameters, bits 1,0,1,0,1 (each with `valid_cmd`): `key_ok` pulses after the 4th bit; after the 5th, `active`=1, `mode`=1, `mode_vld` pulses. Then bit 0 gives `mode`=0.
- `MODE_W`=3, key 1010, then bits 1,1,0: `active` rises only after the 3rd mode bit with `mode`=3'b110. The next 0,0,1 gives `mode`=3'b001. `active` never drops between the two words.
- Defaults, 1,1 repeated three times: three counted failures, then `locked`=1 for 16 cycles. Bits during lockout are ignored. After release, 1,0,1,0,0 gives `active`=1, `mode`=0.
- Defaults, bit 0 sent 10 times: no failures counted, `locked` never asserts, `idx` stays 0.
- `deact` together with `valid_cmd` while ACTIVE: next cycle `active`=0, `mode`=0, and the bit is dropped. `deact` while LOCKED has no effect.
- `reset_n` low mid-key and mid-lockout: all outputs are 0 immediately (asynchronously). After release, a full key works from scratch.
